// File: rtl/shot_sequencer_pkg.sv
// Shared types and default sizes for the shot sequencer.
// The state encodings are visible in the register file, so the values are fixed.
package shot_sequencer_pkg;

    localparam int unsigned NCH_DEF = 6;
    localparam int unsigned SW_DEF  = 16;
    localparam int unsigned TW_DEF  = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/shot_sequencer_if.sv
// Register-file side of the shot sequencer: controls, sample bus and results.
// The master drives controls and samples; the slave (sequencer) returns status and results.
interface shot_sequencer_if #(
    parameter int unsigned NCH = shot_sequencer_pkg::NCH_DEF,
    parameter int unsigned SW  = shot_sequencer_pkg::SW_DEF,
    parameter int unsigned TW  = shot_sequencer_pkg::TW_DEF
);

    logic              arm;
    logic              abort;
    logic [SW-1:0]     midscale;
    logic [SW-1:0]     thresh;
    logic [TW-1:0]     window;
    logic              smp_valid;
    logic [NCH*SW-1:0] smp;

    logic [1:0]        state;
    logic              busy;
    logic              done;
    logic [NCH-1:0]    hit_mask;
    logic [2:0]        first_ch;
    logic [NCH*TW-1:0] ts;
    logic [TW-1:0]     cnt;

    modport master (
        output arm, abort, midscale, thresh, window, smp_valid, smp,
        input  state, busy, done, hit_mask, first_ch, ts, cnt
    );

    modport slave (
        input  arm, abort, midscale, thresh, window, smp_valid, smp,
        output state, busy, done, hit_mask, first_ch, ts, cnt
    );

endinterface

// File: rtl/shot_sequencer_hit_detect.sv
// Single-channel threshold compare: hit when |smp - midscale| > thresh on a valid strobe.
// The difference is taken one bit wider than the sample so it never wraps.
module hit_detect #(
    parameter int unsigned SW = 16
) (
    input  logic [SW-1:0] smp,
    input  logic [SW-1:0] midscale,
    input  logic [SW-1:0] thresh,
    input  logic          valid,
    output logic          hit
);

    logic [SW:0] diff;
    logic [SW:0] dev;

    always_comb begin
        diff = {1'b0, smp} - {1'b0, midscale};
        dev  = diff[SW] ? (~diff + 1'b1) : diff;
        hit  = valid && (dev > {1'b0, thresh});
    end

endmodule

// File: rtl/shot_sequencer.sv
// Shot sequencer: arms on a register pulse, timestamps the first threshold crossing
// per channel relative to the earliest hit, and closes on full mask or window expiry.
module shot_sequencer
    import shot_sequencer_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned SW  = SW_DEF,
    parameter int unsigned TW  = TW_DEF
) (
    input  logic            clk64M,
    input  logic            ares,
    shot_sequencer_if.slave bus
);

    localparam logic [NCH-1:0] AllHit = '1;

    seq_state_t        state_q;
    logic              busy_q;
    logic              done_q;
    logic [NCH-1:0]    mask_q;
    logic [2:0]        first_q;
    logic [NCH*TW-1:0] ts_q;
    logic [TW-1:0]     cnt_q;

    logic [NCH-1:0]    hits;
    logic [NCH-1:0]    new_hits;
    logic [NCH-1:0]    mask_n;
    logic [TW-1:0]     cnt_n;
    logic [2:0]        first_idx;

    for (genvar k = 0; k < NCH; k++) begin : g_hit
        hit_detect #(
            .SW(SW)
        ) u_hit (
            .smp      (bus.smp[k*SW +: SW]),
            .midscale (bus.midscale),
            .thresh   (bus.thresh),
            .valid    (bus.smp_valid),
            .hit      (hits[k])
        );
    end

    always_comb begin
        first_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (hits[k]) first_idx = 3'(k);
        end
        // Tick counter saturates so a very long window cannot alias back to zero.
        cnt_n    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        new_hits = hits & ~mask_q;
        mask_n   = mask_q | new_hits;
    end

    always_ff @(posedge clk64M or posedge ares) begin
        if (ares) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= '0;
            first_q <= '0;
            ts_q    <= '0;
            cnt_q   <= '0;
        end else if (bus.abort) begin
            // Results are kept so software can still read a partial shot.
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.arm) begin
                        state_q <= StArmed;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        mask_q  <= '0;
                        first_q <= '0;
                        ts_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                StArmed: begin
                    if (|hits) begin
                        mask_q  <= hits;
                        first_q <= first_idx;
                        ts_q    <= '0;
                        cnt_q   <= '0;
                        if (hits == AllHit || bus.window == '0) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StCapture;
                        end
                    end
                end
                StCapture: begin
                    if (bus.smp_valid) begin
                        cnt_q  <= cnt_n;
                        mask_q <= mask_n;
                        for (int k = 0; k < NCH; k++) begin
                            if (new_hits[k]) ts_q[k*TW +: TW] <= cnt_n;
                        end
                        if (mask_n == AllHit || cnt_n >= bus.window) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.state    = state_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hit_mask = mask_q;
    assign bus.first_ch = first_q;
    assign bus.ts       = ts_q;
    assign bus.cnt      = cnt_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Bench for shot_sequencer: directed shots plus randomized traffic checked every
// cycle against an integer-level model of the shot rules.
module tb_shot_sequencer;

    localparam int NCH = 6;
    localparam int SW  = 16;
    localparam int TW  = 16;

    localparam int SIdle    = 0;
    localparam int SArmed   = 1;
    localparam int SCapture = 2;
    localparam int SDone    = 3;

    logic clk64M = 1'b0;
    logic ares;

    always #8 clk64M = ~clk64M;

    shot_sequencer_if #(.NCH(NCH), .SW(SW), .TW(TW)) bus ();

    shot_sequencer #(
        .NCH(NCH),
        .SW (SW),
        .TW (TW)
    ) dut (
        .clk64M (clk64M),
        .ares   (ares),
        .bus    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int m_state;
    int m_mask;
    int m_ts[NCH];
    int m_cnt;
    int m_first;
    int smpv[NCH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = SIdle;
        m_mask  = 0;
        m_cnt   = 0;
        m_first = 0;
        for (int k = 0; k < NCH; k++) m_ts[k] = 0;
    endtask

    function automatic int model_hits(input bit v);
        int h = 0;
        int dev;
        if (!v) return 0;
        for (int k = 0; k < NCH; k++) begin
            dev = smpv[k] - int'(bus.midscale);
            if (dev < 0) dev = -dev;
            if (dev > int'(bus.thresh)) h |= (1 << k);
        end
        return h;
    endfunction

    task automatic model_step(input bit a, input bit ab, input bit v);
        int h;
        int win;
        h   = model_hits(v);
        win = int'(bus.window);
        if (ab) begin
            m_state = SIdle;
        end else if (m_state == SIdle || m_state == SDone) begin
            if (a) begin
                m_state = SArmed;
                m_mask  = 0;
                m_cnt   = 0;
                m_first = 0;
                for (int k = 0; k < NCH; k++) m_ts[k] = 0;
            end
        end else if (m_state == SArmed) begin
            if (h != 0) begin
                m_mask  = h;
                m_cnt   = 0;
                m_first = 0;
                while (((h >> m_first) & 1) == 0) m_first++;
                m_state = (h == 63 || win == 0) ? SDone : SCapture;
            end
        end else if (v) begin
            if (m_cnt < 65535) m_cnt++;
            for (int k = 0; k < NCH; k++) begin
                if (((h >> k) & 1) == 1 && ((m_mask >> k) & 1) == 0) begin
                    m_mask |= (1 << k);
                    m_ts[k] = m_cnt;
                end
            end
            if (m_mask == 63 || m_cnt >= win) m_state = SDone;
        end
    endtask

    task automatic check_all();
        check("state", 64'(bus.state), 64'(m_state));
        check("busy", 64'(bus.busy), 64'(m_state == SArmed || m_state == SCapture));
        check("done", 64'(bus.done), 64'(m_state == SDone));
        check("hit_mask", 64'(bus.hit_mask), 64'(m_mask));
        check("first_ch", 64'(bus.first_ch), 64'(m_first));
        check("cnt", 64'(bus.cnt), 64'(m_cnt));
        for (int k = 0; k < NCH; k++)
            check($sformatf("ts%0d", k), 64'(bus.ts[k*TW +: TW]), 64'(m_ts[k]));
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit a, input bit ab, input bit v);
        bus.arm       = a;
        bus.abort     = ab;
        bus.smp_valid = v;
        for (int k = 0; k < NCH; k++) bus.smp[k*SW +: SW] = 16'(smpv[k]);
        model_step(a, ab, v);
        @(posedge clk64M);
        #1;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        bus.smp_valid = 1'b0;
        check_all();
    endtask

    task automatic quiet();
        for (int k = 0; k < NCH; k++) smpv[k] = 'h8000;
    endtask

    initial begin
        int hs[NCH];
        int off;
        ares          = 1'b1;
        bus.arm       = 1'b0;
        bus.abort     = 1'b0;
        bus.smp_valid = 1'b0;
        bus.smp       = '0;
        bus.midscale  = 16'h8000;
        bus.thresh    = 16'h1000;
        bus.window    = 16'd100;
        quiet();
        model_reset();
        #5;
        check_all();
        @(negedge clk64M);
        ares = 1'b0;
        @(posedge clk64M);
        #1;

        // Staggered shot: ch3-5 sit exactly on the threshold and never count.
        step(1, 0, 0);
        check("t2_armed", 64'(bus.state), 64'(SArmed));
        for (int i = 0; i <= 100; i++) begin
            smpv[0] = 'hA000;
            smpv[1] = (i >= 3) ? 'hA000 : 'h8000;
            smpv[2] = (i >= 7) ? 'hA000 : 'h8000;
            for (int k = 3; k < NCH; k++) smpv[k] = (i >= 2) ? 'h7000 : 'h8000;
            step(0, 0, 1);
            if (i == 99) check("t2_still_capture", 64'(bus.state), 64'(SCapture));
        end
        check("t2_state", 64'(bus.state), 64'(SDone));
        check("t2_mask", 64'(bus.hit_mask), 64'h07);
        check("t2_ts1", 64'(bus.ts[1*TW +: TW]), 64'd3);
        check("t2_ts2", 64'(bus.ts[2*TW +: TW]), 64'd7);
        check("t2_first", 64'(bus.first_ch), 64'd0);

        // All six channels hit by strobe 12 with a long window.
        bus.window = 16'd1000;
        hs = '{0, 2, 4, 6, 9, 12};
        quiet();
        step(1, 0, 0);
        for (int i = 0; i <= 12; i++) begin
            for (int k = 0; k < NCH; k++) smpv[k] = (i >= hs[k]) ? 'hA000 : 'h8000;
            step(0, 0, 1);
        end
        check("t3_state", 64'(bus.state), 64'(SDone));
        check("t3_mask", 64'(bus.hit_mask), 64'h3F);
        check("t3_cnt", 64'(bus.cnt), 64'd12);

        // Simultaneous first hit on ch2/ch4; ch5 exactly at threshold.
        quiet();
        step(1, 0, 0);
        smpv[2] = 'h9001;
        smpv[4] = 'h9001;
        smpv[5] = 'h9000;
        step(0, 0, 1);
        check("t4_mask", 64'(bus.hit_mask), 64'h14);
        check("t4_first", 64'(bus.first_ch), 64'd2);
        smpv[0] = 'h6FFF;
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 1, 0);
        check("t4_abort_state", 64'(bus.state), 64'(SIdle));
        check("t4_abort_mask", 64'(bus.hit_mask), 64'h15);

        // Zero window closes on the first-hit edge.
        bus.window = 16'd0;
        quiet();
        step(1, 0, 0);
        smpv[3] = 'h6000;
        step(0, 0, 1);
        check("t5_state", 64'(bus.state), 64'(SDone));
        check("t5_mask", 64'(bus.hit_mask), 64'h08);

        // Control races.
        step(1, 1, 0);
        check("t6_arm_abort", 64'(bus.state), 64'(SIdle));
        bus.window = 16'd5;
        smpv[1] = 'hA000;
        step(1, 0, 1);
        check("t6_arm_smp_mask", 64'(bus.hit_mask), 64'h00);
        step(0, 0, 1);
        quiet();
        step(1, 0, 1);
        check("t6_arm_in_capture", 64'(bus.state), 64'(SCapture));
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        check("t6_done", 64'(bus.state), 64'(SDone));
        step(1, 0, 0);
        check("t6_rearm_state", 64'(bus.state), 64'(SArmed));
        check("t6_rearm_mask", 64'(bus.hit_mask), 64'h00);
        check("t6_rearm_ts", 64'(bus.ts), 64'h0);

        // Asynchronous reset mid-capture, checked before any further edge.
        bus.window = 16'd50;
        smpv[4] = 'h5000;
        step(0, 0, 1);
        step(0, 0, 1);
        check("t1_capture", 64'(bus.state), 64'(SCapture));
        ares = 1'b1;
        #2;
        model_reset();
        check("t1_rst_state", 64'(bus.state), 64'd0);
        check("t1_rst_mask", 64'(bus.hit_mask), 64'd0);
        check("t1_rst_ts", 64'(bus.ts), 64'd0);
        check("t1_rst_busy", 64'(bus.busy), 64'd0);
        check("t1_rst_done", 64'(bus.done), 64'd0);
        ares = 1'b0;
        quiet();

        // Randomized traffic with occasional on-the-fly config changes.
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                bus.midscale = 16'($urandom_range(16'h4000, 16'hC000));
                bus.thresh   = 16'($urandom_range(16'h0800, 16'h1400));
                bus.window   = 16'($urandom_range(0, 20));
            end
            for (int k = 0; k < NCH; k++) begin
                off = int'($urandom_range(0, 16'h2C00)) - 'h1600;
                if ($urandom_range(0, 9) == 0)
                    off = ($urandom_range(0, 1) == 1) ? int'(bus.thresh) : -int'(bus.thresh);
                smpv[k] = int'(bus.midscale) + off;
            end
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
